// File: rtl/mor1kx_branch_predictor_gshare_param_if.sv
// mor1kx_branch_predictor_gshare_param_if: decode/execute branch signals between the pipeline and the predictor
interface mor1kx_branch_predictor_gshare_param_if #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int STAT_WIDTH = 16
);
  logic predicted_flag_o;
  logic op_bf_i;
  logic op_bnf_i;
  logic padv_decode_i;
  logic execute_op_bf_i;
  logic execute_op_bnf_i;
  logic flag_i;
  logic prev_op_brcond_i;
  logic branch_mispredict_i;
  logic [OPTION_OPERAND_WIDTH-1:0] brn_pc_i;
  logic flush_i;
  logic stat_clear_i;
  logic init_busy_o;
  logic [STAT_WIDTH-1:0] stat_branches_o;
  logic [STAT_WIDTH-1:0] stat_mispredicts_o;
  modport master (
    output op_bf_i, op_bnf_i, padv_decode_i, execute_op_bf_i, execute_op_bnf_i, flag_i,
           prev_op_brcond_i, branch_mispredict_i, brn_pc_i, flush_i, stat_clear_i,
    input  predicted_flag_o, init_busy_o, stat_branches_o, stat_mispredicts_o
  );
  modport slave (
    input  op_bf_i, op_bnf_i, padv_decode_i, execute_op_bf_i, execute_op_bnf_i, flag_i,
           prev_op_brcond_i, branch_mispredict_i, brn_pc_i, flush_i, stat_clear_i,
    output predicted_flag_o, init_busy_o, stat_branches_o, stat_mispredicts_o
  );
endinterface

// File: rtl/mor1kx_branch_predictor_gshare_param.sv
// mor1kx_branch_predictor_gshare_param: gshare/gselect/bimodal predictor with sequential table init and stats
module mor1kx_branch_predictor_gshare_param #(
  parameter int GSHARE_BITS_NUM = 10,
  parameter int HISTORY_BITS = 10,
  parameter int COUNTER_BITS = 2,
  parameter int INIT_COUNTER = 2**(COUNTER_BITS-1),
  parameter int HASH_MODE = 0,
  parameter int STAT_WIDTH = 16,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  mor1kx_branch_predictor_gshare_param_if.slave bp
);
  localparam int FSM_NUM = 2**GSHARE_BITS_NUM;
  localparam int L = GSHARE_BITS_NUM/2;
  localparam int U = GSHARE_BITS_NUM-L;
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q;
  logic [COUNTER_BITS-1:0] table_q [FSM_NUM];
  logic [HISTORY_BITS-1:0] hist_q, hist_d;
  logic [GSHARE_BITS_NUM-1:0] init_ptr_q, prev_idx_q, idx;
  logic [COUNTER_BITS-1:0] cnt, cnt_d;
  logic [STAT_WIDTH-1:0] br_q, mis_q;
  logic busy, train, taken, t;
  assign busy = state_q == INIT;
  if (HASH_MODE == 1) begin : g_gselect
    logic [L-1:0] hl;
    assign hl = L'(hist_q);
    assign idx = {hl, bp.brn_pc_i[U+1:2]};
  end else if (HASH_MODE == 2) begin : g_bimodal
    assign idx = bp.brn_pc_i[GSHARE_BITS_NUM+1:2];
  end else begin : g_gshare
    assign idx = GSHARE_BITS_NUM'(hist_q) ^ bp.brn_pc_i[GSHARE_BITS_NUM+1:2];
  end
  if (HISTORY_BITS == 1) begin : g_h1
    assign hist_d = taken;
  end else begin : g_hn
    assign hist_d = {hist_q[HISTORY_BITS-2:0], taken};
  end
  assign t = table_q[idx][COUNTER_BITS-1] & !busy;
  assign bp.predicted_flag_o = (t & bp.op_bf_i) | (!t & bp.op_bnf_i);
  assign train = bp.prev_op_brcond_i & bp.padv_decode_i & !busy;
  assign taken = (bp.execute_op_bf_i & bp.flag_i) | (bp.execute_op_bnf_i & !bp.flag_i);
  assign cnt = table_q[prev_idx_q];
  assign cnt_d = taken ? (&cnt ? cnt : cnt + 1'b1) : (|cnt ? cnt - 1'b1 : cnt);
  assign bp.init_busy_o = busy;
  assign bp.stat_branches_o = br_q;
  assign bp.stat_mispredicts_o = mis_q;
  // Table has no reset: the INIT sweep fills it after every reset release
  always_ff @(posedge clk)
    if (busy) table_q[init_ptr_q] <= COUNTER_BITS'(INIT_COUNTER);
    else if (train) table_q[prev_idx_q] <= cnt_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= INIT;
      init_ptr_q <= '0;
      prev_idx_q <= '0;
      hist_q <= '0;
      br_q <= '0;
      mis_q <= '0;
    end else begin
      if (busy) init_ptr_q <= init_ptr_q + 1'b1;
      if (busy && &init_ptr_q) state_q <= RUN;
      if ((bp.op_bf_i | bp.op_bnf_i) & bp.padv_decode_i) prev_idx_q <= idx;
      if (bp.flush_i) hist_q <= '0;
      else if (train) hist_q <= hist_d;
      br_q <= bp.stat_clear_i ? '0 : (train && !(&br_q)) ? br_q + 1'b1 : br_q;
      mis_q <= bp.stat_clear_i ? '0 : (train && bp.branch_mispredict_i && !(&mis_q)) ? mis_q + 1'b1 : mis_q;
    end
endmodule

// File: tb/tb_mor1kx_branch_predictor_gshare_param.sv
// tb_mor1kx_branch_predictor_gshare_param: directed checks on gshare, gselect and bimodal instances
module tb_mor1kx_branch_predictor_gshare_param;
  logic clk, rst, op_bf, op_bnf, padv, ex_bf, ex_bnf, flag, brcond, mispred, flush, sclr;
  logic [31:0] pc;
  logic [2:0] sel;
  int tests, fails;

  mor1kx_branch_predictor_gshare_param_if #(.OPTION_OPERAND_WIDTH(32), .STAT_WIDTH(4)) b0 ();
  mor1kx_branch_predictor_gshare_param_if #(.OPTION_OPERAND_WIDTH(32), .STAT_WIDTH(16)) b1 ();
  mor1kx_branch_predictor_gshare_param_if #(.OPTION_OPERAND_WIDTH(32), .STAT_WIDTH(16)) b2 ();

  assign b0.op_bf_i = op_bf; assign b0.op_bnf_i = op_bnf; assign b0.padv_decode_i = padv & sel[0];
  assign b0.execute_op_bf_i = ex_bf; assign b0.execute_op_bnf_i = ex_bnf; assign b0.flag_i = flag;
  assign b0.prev_op_brcond_i = brcond; assign b0.branch_mispredict_i = mispred; assign b0.brn_pc_i = pc;
  assign b0.flush_i = flush & sel[0]; assign b0.stat_clear_i = sclr & sel[0];
  assign b1.op_bf_i = op_bf; assign b1.op_bnf_i = op_bnf; assign b1.padv_decode_i = padv & sel[1];
  assign b1.execute_op_bf_i = ex_bf; assign b1.execute_op_bnf_i = ex_bnf; assign b1.flag_i = flag;
  assign b1.prev_op_brcond_i = brcond; assign b1.branch_mispredict_i = mispred; assign b1.brn_pc_i = pc;
  assign b1.flush_i = flush & sel[1]; assign b1.stat_clear_i = sclr & sel[1];
  assign b2.op_bf_i = op_bf; assign b2.op_bnf_i = op_bnf; assign b2.padv_decode_i = padv & sel[2];
  assign b2.execute_op_bf_i = ex_bf; assign b2.execute_op_bnf_i = ex_bnf; assign b2.flag_i = flag;
  assign b2.prev_op_brcond_i = brcond; assign b2.branch_mispredict_i = mispred; assign b2.brn_pc_i = pc;
  assign b2.flush_i = flush & sel[2]; assign b2.stat_clear_i = sclr & sel[2];

  mor1kx_branch_predictor_gshare_param #(.GSHARE_BITS_NUM(4), .HISTORY_BITS(4), .HASH_MODE(0), .STAT_WIDTH(4))
    u0 (.clk(clk), .rst(rst), .bp(b0));
  mor1kx_branch_predictor_gshare_param #(.GSHARE_BITS_NUM(4), .HISTORY_BITS(2), .HASH_MODE(1), .STAT_WIDTH(16))
    u1 (.clk(clk), .rst(rst), .bp(b1));
  mor1kx_branch_predictor_gshare_param #(.GSHARE_BITS_NUM(4), .HISTORY_BITS(4), .HASH_MODE(2), .STAT_WIDTH(16))
    u2 (.clk(clk), .rst(rst), .bp(b2));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic predict(input int k, input logic [31:0] a, input logic bnf, output logic p);
    pc = a; op_bf = !bnf; op_bnf = bnf; padv = 1;
    #1 p = k == 0 ? b0.predicted_flag_o : k == 1 ? b1.predicted_flag_o : b2.predicted_flag_o;
    tick;
    op_bf = 0; op_bnf = 0; padv = 0;
  endtask

  task automatic train(input logic tk, input logic m, input logic bnf);
    brcond = 1; padv = 1; ex_bf = !bnf; ex_bnf = bnf; flag = bnf ? !tk : tk; mispred = m;
    tick;
    brcond = 0; padv = 0; ex_bf = 0; ex_bnf = 0; flag = 0; mispred = 0;
  endtask

  task automatic test_reset;
    @(negedge clk); tick;
    op_bf = 1;
    #1;
    tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b111) begin fails++; $display("FAIL reset_busy: got %b want 111", {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
    tests++; if ({b0.stat_branches_o, b0.stat_mispredicts_o} !== 8'h00) begin fails++; $display("FAIL reset_stats: got %h want 00", {b0.stat_branches_o, b0.stat_mispredicts_o}); end
    tests++; if (b0.predicted_flag_o !== 1'b0) begin fails++; $display("FAIL reset_pred: got %b want 0", b0.predicted_flag_o); end
    op_bf = 0;
  endtask

  task automatic test_init;
    @(negedge clk);
    op_bf = 1; padv = 1; brcond = 1; ex_bf = 1; flag = 1; mispred = 1; pc = 0;
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b111) begin fails++; $display("FAIL init_busy cycle %0d: got %b want 111", i, {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
      if (i == 0 || i == 15) begin
        tests++; if (b0.predicted_flag_o !== 1'b0) begin fails++; $display("FAIL init_pred cycle %0d: got %b want 0", i, b0.predicted_flag_o); end
      end
      tick;
    end
    #1;
    tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b000) begin fails++; $display("FAIL init_done: got %b want 000", {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
    tests++; if ({b0.predicted_flag_o, b1.predicted_flag_o, b2.predicted_flag_o} !== 3'b111) begin fails++; $display("FAIL init_weak_taken: got %b want 111", {b0.predicted_flag_o, b1.predicted_flag_o, b2.predicted_flag_o}); end
    tests++; if (b0.stat_branches_o !== 4'd0 || b1.stat_branches_o !== 16'd0 || b2.stat_mispredicts_o !== 16'd0) begin fails++; $display("FAIL init_train_dropped: got %0d %0d %0d want 0 0 0", b0.stat_branches_o, b1.stat_branches_o, b2.stat_mispredicts_o); end
    op_bf = 0; padv = 0; brcond = 0; ex_bf = 0; flag = 0; mispred = 0;
  endtask

  task automatic test_bimodal;
    logic p;
    sel = 3'b100;
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL bim_init: got %b want 1", p); end
    train(0, 0, 0);
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL bim_n1: got %b want 0", p); end
    train(0, 0, 0); train(0, 0, 0); train(0, 0, 0);
    predict(2, 32'h10, 1, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL bim_sat0_bnf: got %b want 1", p); end
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL bim_sat0_bf: got %b want 0", p); end
    train(1, 0, 0);
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL bim_t1: got %b want 0", p); end
    train(1, 0, 0);
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL bim_t2: got %b want 1", p); end
    predict(2, 32'h14, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL bim_other: got %b want 1", p); end
    tests++; if (b2.stat_branches_o !== 16'd6 || b2.stat_mispredicts_o !== 16'd0) begin fails++; $display("FAIL bim_stats: got %0d %0d want 6 0", b2.stat_branches_o, b2.stat_mispredicts_o); end
  endtask

  task automatic test_back_to_back;
    logic p;
    sel = 3'b100;
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL b2b_pre: got %b want 1", p); end
    pc = 32'h18; op_bf = 1; padv = 1; brcond = 1; ex_bf = 1; flag = 0;
    tick;
    op_bf = 0; padv = 0; brcond = 0; ex_bf = 0;
    train(0, 0, 0);
    predict(2, 32'h10, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL b2b_old_idx: got %b want 0", p); end
    predict(2, 32'h18, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL b2b_new_idx: got %b want 0", p); end
    predict(2, 32'h14, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL b2b_untouched: got %b want 1", p); end
    tests++; if (b2.stat_branches_o !== 16'd8) begin fails++; $display("FAIL b2b_stats: got %0d want 8", b2.stat_branches_o); end
  endtask

  task automatic test_gshare;
    logic p;
    sel = 3'b001;
    predict(0, 32'h20, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gs_e8_init: got %b want 1", p); end
    train(0, 0, 0); train(0, 0, 0);
    predict(0, 32'h0, 0, p);
    train(1, 0, 1); train(0, 0, 1); train(1, 0, 1); train(0, 0, 1);
    predict(0, 32'h8, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL gs_hist1010: got %b want 0", p); end
    flush = 1; tick; flush = 0;
    predict(0, 32'h8, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gs_flush: got %b want 1", p); end
    predict(0, 32'h20, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL gs_e8: got %b want 0", p); end
    flush = 1; train(1, 0, 0); flush = 0;
    predict(0, 32'h20, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL gs_flush_train: got %b want 0", p); end
    train(1, 0, 0);
    predict(0, 32'h24, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gs_cnt_and_hist: got %b want 1", p); end
    tests++; if (b0.stat_branches_o !== 4'd8 || b0.stat_mispredicts_o !== 4'd0) begin fails++; $display("FAIL gs_stats: got %0d %0d want 8 0", b0.stat_branches_o, b0.stat_mispredicts_o); end
  endtask

  task automatic test_stats;
    sel = 3'b001;
    for (int i = 0; i < 20; i++) train(1, 1, 0);
    tests++; if (b0.stat_branches_o !== 4'd15 || b0.stat_mispredicts_o !== 4'd15) begin fails++; $display("FAIL stat_saturate: got %0d %0d want 15 15", b0.stat_branches_o, b0.stat_mispredicts_o); end
    sclr = 1; train(1, 1, 0); sclr = 0;
    tests++; if (b0.stat_branches_o !== 4'd0 || b0.stat_mispredicts_o !== 4'd0) begin fails++; $display("FAIL stat_clear_wins: got %0d %0d want 0 0", b0.stat_branches_o, b0.stat_mispredicts_o); end
    train(0, 1, 0);
    tests++; if (b0.stat_branches_o !== 4'd1 || b0.stat_mispredicts_o !== 4'd1) begin fails++; $display("FAIL stat_after_clear: got %0d %0d want 1 1", b0.stat_branches_o, b0.stat_mispredicts_o); end
  endtask

  task automatic test_gselect;
    logic p;
    sel = 3'b010;
    train(1, 0, 0); train(1, 0, 0);
    predict(1, 32'h4, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gsel_e13_init: got %b want 1", p); end
    train(0, 0, 0); train(0, 0, 0);
    predict(1, 32'h0, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gsel_e0: got %b want 1", p); end
    train(1, 0, 0); train(1, 0, 0);
    predict(1, 32'h4, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL gsel_idx13: got %b want 0", p); end
    predict(1, 32'h4, 1, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gsel_bnf: got %b want 1", p); end
    predict(1, 32'h8, 0, p);
    tests++; if (p !== 1'b1) begin fails++; $display("FAIL gsel_idx14: got %b want 1", p); end
    predict(1, 32'h14, 0, p);
    tests++; if (p !== 1'b0) begin fails++; $display("FAIL gsel_pc_hi_ignored: got %b want 0", p); end
  endtask

  task automatic test_reset_mid_init;
    sel = 3'b111;
    rst = 0; tick; rst = 1;
    repeat (7) tick;
    rst = 0;
    #1;
    tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b111) begin fails++; $display("FAIL mid_busy: got %b want 111", {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
    tests++; if (b0.stat_branches_o !== 4'd0) begin fails++; $display("FAIL mid_stats: got %0d want 0", b0.stat_branches_o); end
    tick;
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b111) begin fails++; $display("FAIL mid_resweep cycle %0d: got %b want 111", i, {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
      tick;
    end
    #1;
    tests++; if ({b0.init_busy_o, b1.init_busy_o, b2.init_busy_o} !== 3'b000) begin fails++; $display("FAIL mid_done: got %b want 000", {b0.init_busy_o, b1.init_busy_o, b2.init_busy_o}); end
    op_bf = 1; pc = 32'h10;
    #1;
    tests++; if (b2.predicted_flag_o !== 1'b1) begin fails++; $display("FAIL mid_reinit: got %b want 1", b2.predicted_flag_o); end
    op_bf = 0;
  endtask

  initial begin
    clk = 0; rst = 0; sel = 3'b111; pc = 0;
    op_bf = 0; op_bnf = 0; padv = 0; ex_bf = 0; ex_bnf = 0; flag = 0;
    brcond = 0; mispred = 0; flush = 0; sclr = 0;
    tests = 0; fails = 0;
    test_reset;
    test_init;
    test_bimodal;
    test_back_to_back;
    test_gshare;
    test_stats;
    test_gselect;
    test_reset_mid_init;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
